// File: rtl/uart_rx.sv
// uart_rx: standalone 8N1 UART receiver with mid-bit sampling.
//
// The serial input is synchronised and then sampled in the middle of each
// bit. A low pulse shorter than half a bit is rejected as a glitch. A stop
// bit sampled low is reported as a framing error. The receiver then waits in
// BREAK until the line returns high.
//
// Ports:
//   ipClk         system clock
//   ipReset       asynchronous active-low reset
//   ipRx          serial data in, idle high, asynchronous to ipClk
//   opRxData      last correctly received byte, held until the next good frame
//   opRxValid     one-cycle strobe; opRxData is valid in that cycle
//   opFrameError  one-cycle strobe; the stop bit was sampled low
//   opBusy        high from start-bit detection until the return to IDLE
//   opParityError one-cycle strobe on a parity mismatch (UART_RX_PARITY_EN only)
//
// Optional feature: define UART_RX_PARITY_EN for 8E1 framing. With the macro
// defined, an even-parity bit follows data bit 7 and opParityError is added.

module uart_rx #(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200
) (
    input  logic       ipClk,
    input  logic       ipReset,
    input  logic       ipRx,
    output logic [7:0] opRxData,
    output logic       opRxValid,
    output logic       opFrameError,
`ifdef UART_RX_PARITY_EN
    output logic       opParityError,
`endif
    output logic       opBusy
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int HALF         = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BREAK
    } stateT;

    stateT         state, nextState;
    logic          rxMeta, rxS;
    logic [CW-1:0] cnt;
    logic [2:0]    bitIdx;
    logic [7:0]    shiftReg;
    logic          cntClr, shiftEn, frameGood, frameBad;
`ifdef UART_RX_PARITY_EN
    logic          parSample, parBad;
`endif

    // Both flops reset to 1 so that reset does not look like a start bit.
    always_ff @(posedge ipClk or negedge ipReset) begin
        if (!ipReset) begin
            rxMeta <= 1'b1;
            rxS    <= 1'b1;
        end else begin
            rxMeta <= ipRx;
            rxS    <= rxMeta;
        end
    end

    // The counter restarts at every sample point. In START it counts half a
    // bit. In later states it counts whole bits, so every later sample lands
    // mid-bit.
    always_comb begin
        nextState = state;
        cntClr    = 1'b0;
        shiftEn   = 1'b0;
        frameGood = 1'b0;
        frameBad  = 1'b0;
`ifdef UART_RX_PARITY_EN
        parSample = 1'b0;
`endif
        case (state)
            IDLE: begin
                cntClr = 1'b1;
                if (!rxS) nextState = START;
            end
            START: begin
                if (cnt == CW'(HALF - 1)) begin
                    cntClr    = 1'b1;
                    nextState = rxS ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == CW'(CLKS_PER_BIT - 1)) begin
                    cntClr  = 1'b1;
                    shiftEn = 1'b1;
`ifdef UART_RX_PARITY_EN
                    if (bitIdx == 3'd7) nextState = PARITY;
`else
                    if (bitIdx == 3'd7) nextState = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt == CW'(CLKS_PER_BIT - 1)) begin
                    cntClr    = 1'b1;
                    parSample = 1'b1;
                    nextState = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt == CW'(CLKS_PER_BIT - 1)) begin
                    cntClr = 1'b1;
                    if (rxS) begin
                        frameGood = 1'b1;
                        nextState = IDLE;
                    end else begin
                        frameBad  = 1'b1;
                        nextState = BREAK;
                    end
                end
            end
            BREAK: begin
                // Hold off start detection until the line has gone high again.
                cntClr = 1'b1;
                if (rxS) nextState = IDLE;
            end
            default: begin
                cntClr    = 1'b1;
                nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge ipClk or negedge ipReset) begin
        if (!ipReset) begin
            state        <= IDLE;
            cnt          <= '0;
            bitIdx       <= '0;
            shiftReg     <= '0;
            opRxData     <= '0;
            opRxValid    <= 1'b0;
            opFrameError <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parBad        <= 1'b0;
            opParityError <= 1'b0;
`endif
        end else begin
            state        <= nextState;
            cnt          <= cntClr ? '0 : cnt + 1'b1;
            opRxValid    <= 1'b0;
            opFrameError <= 1'b0;
            if (state == IDLE)
                bitIdx <= '0;
            else if (shiftEn)
                bitIdx <= bitIdx + 1'b1;
            if (shiftEn)
                shiftReg <= {rxS, shiftReg[7:1]};   // LSB arrives first
`ifdef UART_RX_PARITY_EN
            opParityError <= 1'b0;
            // Even parity: data bits plus the parity bit must XOR to 0.
            if (parSample)
                parBad <= (^shiftReg) ^ rxS;
            if (frameGood) begin
                if (parBad) begin
                    opParityError <= 1'b1;
                end else begin
                    opRxValid <= 1'b1;
                    opRxData  <= shiftReg;
                end
            end
`else
            if (frameGood) begin
                opRxValid <= 1'b1;
                opRxData  <= shiftReg;
            end
`endif
            if (frameBad)
                opFrameError <= 1'b1;
        end
    end

    assign opBusy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and random frames for uart_rx.
// Results are compared against a reference model that works at frame level.
// The model predicts each strobe cycle from the start-edge cycle and the
// frame timing rules. Strobes seen on the outputs are queued, then compared
// entry by entry against the predictions.

module tb_uart_rx;
    localparam int CLK_HZ = 50000000;
    localparam int BAUD   = 115200;
    localparam int BITC   = CLK_HZ / BAUD;
    localparam int HALFB  = BITC / 2;
`ifdef UART_RX_PARITY_EN
    localparam int STOPIX = 10;
`else
    localparam int STOPIX = 9;
`endif
    // Start edge -> strobe: 2 synchroniser cycles, half a bit to the start
    // sample, STOPIX bits to the stop sample, 1 cycle to register the strobe.
    localparam int LAT = 2 + HALFB + STOPIX * BITC + 1;

    typedef struct {
        int         cyc;
        logic [7:0] d;
    } evT;

    logic       ipClk   = 1'b0;
    logic       ipReset = 1'b1;
    logic       ipRx    = 1'b1;
    logic [7:0] opRxData;
    logic       opRxValid, opFrameError, opBusy;
`ifdef UART_RX_PARITY_EN
    logic       opParityError;
`endif

    uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .ipClk        (ipClk),
        .ipReset      (ipReset),
        .ipRx         (ipRx),
        .opRxData     (opRxData),
        .opRxValid    (opRxValid),
        .opFrameError (opFrameError),
`ifdef UART_RX_PARITY_EN
        .opParityError(opParityError),
`endif
        .opBusy       (opBusy)
    );

    always #10 ipClk = ~ipClk;

    int cyc = 0;
    always @(posedge ipClk) cyc <= cyc + 1;

    evT   gotQ[$], expQ[$];
    int   gotFerr[$], expFerr[$], gotPerr[$], expPerr[$];
    logic busySeen = 1'b0;
    logic bothSeen = 1'b0;
    int   passed = 0;
    int   total  = 0;

    // Collect strobes away from the active edge.
    always @(negedge ipClk) begin
        if (opRxValid) gotQ.push_back('{cyc, opRxData});
        if (opFrameError) gotFerr.push_back(cyc);
`ifdef UART_RX_PARITY_EN
        if (opParityError) gotPerr.push_back(cyc);
`endif
        if (opRxValid && opFrameError) bothSeen = 1'b1;
        if (opBusy) busySeen = 1'b1;
    end

    task automatic tick();
        @(posedge ipClk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Model: the expected outcome of a frame depends only on its start cycle
    // and whether its parity is good.
    task automatic frame(input logic [7:0] d, input logic badPar);
        int s;
        s = cyc;
        if (badPar) expPerr.push_back(s + LAT);
        else expQ.push_back('{s + LAT, d});
        ipRx = 1'b0;
        repeat (BITC) tick();
        for (int i = 0; i < 8; i++) begin
            ipRx = d[i];
            repeat (BITC) tick();
        end
`ifdef UART_RX_PARITY_EN
        ipRx = (^d) ^ badPar;
        repeat (BITC) tick();
`endif
        ipRx = 1'b1;
        repeat (BITC) tick();
    endtask

    task automatic checkAll(input string tag);
        chk({tag, " rxValid count"}, 32'(gotQ.size()), 32'(expQ.size()));
        for (int i = 0; i < expQ.size() && i < gotQ.size(); i++) begin
            chk({tag, " rxValid cycle"}, 32'(gotQ[i].cyc), 32'(expQ[i].cyc));
            chk({tag, " rxData"}, 32'(gotQ[i].d), 32'(expQ[i].d));
        end
        chk({tag, " frameError count"}, 32'(gotFerr.size()), 32'(expFerr.size()));
        for (int i = 0; i < expFerr.size() && i < gotFerr.size(); i++)
            chk({tag, " frameError cycle"}, 32'(gotFerr[i]), 32'(expFerr[i]));
        chk({tag, " parityError count"}, 32'(gotPerr.size()), 32'(expPerr.size()));
        for (int i = 0; i < expPerr.size() && i < gotPerr.size(); i++)
            chk({tag, " parityError cycle"}, 32'(gotPerr[i]), 32'(expPerr[i]));
        gotQ.delete(); expQ.delete();
        gotFerr.delete(); expFerr.delete();
        gotPerr.delete(); expPerr.delete();
    endtask

    initial begin
        int s;
        logic [7:0] r;
        logic [7:0] f0;

        // Reset, then an idle line for 1000 cycles.
        #5 ipReset = 1'b0;
        repeat (3) tick();
        chk("reset rxData", 32'(opRxData), 32'h00);
        chk("reset rxValid", 32'(opRxValid), 32'h0);
        chk("reset frameError", 32'(opFrameError), 32'h0);
        chk("reset busy", 32'(opBusy), 32'h0);
        ipReset = 1'b1;
        busySeen = 1'b0;
        repeat (1000) tick();
        chk("idle busy", 32'(busySeen), 32'h0);
        checkAll("idle");

        // Single frame.
        frame(8'hA5, 1'b0);
        repeat (50) tick();
        checkAll("A5");

        // A 100-cycle low glitch is rejected at the half-bit sample.
        s = cyc;
        ipRx = 1'b0;
        repeat (100) tick();
        chk("glitch busy during", 32'(opBusy), 32'h1);
        ipRx = 1'b1;
        repeat (130) tick();
        chk("glitch busy after", 32'(opBusy), 32'h0);
        repeat (100) tick();
        checkAll("glitch");
        frame(8'h3C, 1'b0);
        repeat (50) tick();
        checkAll("3C");

        // Back-to-back frames with no gap; expected cycles sit 10 bits apart.
        frame(8'h55, 1'b0);
        frame(8'hAA, 1'b0);
        repeat (50) tick();
        checkAll("b2b");

        // Break: 00 with the line held low for 20 bit times.
        s = cyc;
        expFerr.push_back(s + LAT);
        ipRx = 1'b0;
        repeat (20 * BITC) tick();
        chk("break busy held", 32'(opBusy), 32'h1);
        ipRx = 1'b1;
        repeat (BITC) tick();
        chk("break busy released", 32'(opBusy), 32'h0);
        chk("break rxData held", 32'(opRxData), 32'hAA);
        checkAll("break");
        frame(8'h81, 1'b0);
        repeat (50) tick();
        checkAll("81");

        // Reset asserted during data bit 4 of F0.
        f0 = 8'hF0;
        ipRx = 1'b0;
        repeat (BITC) tick();
        for (int i = 0; i < 5; i++) begin
            ipRx = f0[i];
            repeat (i == 4 ? 200 : BITC) tick();
        end
        ipReset = 1'b0;
        #1;
        chk("midreset rxData", 32'(opRxData), 32'h00);
        chk("midreset rxValid", 32'(opRxValid), 32'h0);
        chk("midreset frameError", 32'(opFrameError), 32'h0);
        chk("midreset busy", 32'(opBusy), 32'h0);
        repeat (5) tick();
        ipRx = 1'b1;
        ipReset = 1'b1;
        repeat (BITC) tick();
        checkAll("midreset");
        frame(8'h0F, 1'b0);
        repeat (50) tick();
        checkAll("0F");

        // Random bytes, back to back.
        for (int i = 0; i < 4; i++) begin
            r = 8'($urandom_range(0, 255));
            frame(r, 1'b0);
        end
        repeat (50) tick();
        checkAll("random");

`ifdef UART_RX_PARITY_EN
        frame(8'h03, 1'b0);
        frame(8'h03, 1'b1);
        repeat (50) tick();
        checkAll("parity");
        chk("parity rxData held", 32'(opRxData), 32'h03);
`endif

        chk("strobe exclusivity", 32'(bothSeen), 32'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
